// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch-side handshake bundle: control in, icache request/response, pipeline register outputs
interface fetch_unit_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  stall_in;
  logic                  branch_taken_in;
  logic [WORD_WIDTH-1:0] branch_target_in;
  logic                  icache_req_out;
  logic [WORD_WIDTH-1:0] icache_addr_out;
  logic                  icache_ready_in;
  logic [WORD_WIDTH-1:0] icache_data_in;
  logic [WORD_WIDTH-1:0] instruction_out;
  logic [WORD_WIDTH-1:0] rm0_out;
  logic                  cache_op_done_out;
  logic                  set_nop_out;

  modport master (
    input  stall_in, branch_taken_in, branch_target_in, icache_ready_in, icache_data_in,
    output icache_req_out, icache_addr_out, instruction_out, rm0_out, cache_op_done_out, set_nop_out
  );

  modport slave (
    output stall_in, branch_taken_in, branch_target_in, icache_ready_in, icache_data_in,
    input  icache_req_out, icache_addr_out, instruction_out, rm0_out, cache_op_done_out, set_nop_out
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and icache request FSM feeding the fetch pipeline registers
module fetch_unit #(
  parameter int                    WORD_WIDTH      = 32,
  parameter logic [WORD_WIDTH-1:0] BOOT_ADDRESS    = 32'h0000_1000,
  parameter int                    PC_STEP         = 4,
  parameter logic [WORD_WIDTH-1:0] NOP_INSTRUCTION = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  fetch_unit_if.master      bus
);

  typedef enum logic [1:0] {IDLE, WAIT, VALID, DRAIN} state_t;

  state_t                r_state, w_state;
  logic [WORD_WIDTH-1:0] r_pc, w_pc;
  logic                  r_req, w_req;
  logic [WORD_WIDTH-1:0] r_addr, w_addr;
  logic [WORD_WIDTH-1:0] r_instr, w_instr;
  logic [WORD_WIDTH-1:0] r_rm0, w_rm0;
  logic                  r_done, w_done;
  logic                  r_nop, w_nop;
  logic [WORD_WIDTH-1:0] w_target;
  logic [WORD_WIDTH-1:0] w_pc_inc;

  assign w_target = {bus.branch_target_in[WORD_WIDTH-1:2], 2'b00};
  assign w_pc_inc = r_pc + WORD_WIDTH'(PC_STEP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pc    <= BOOT_ADDRESS;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_instr <= NOP_INSTRUCTION;
      r_rm0   <= '0;
      r_done  <= 1'b0;
      r_nop   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_req   <= w_req;
      r_addr  <= w_addr;
      r_instr <= w_instr;
      r_rm0   <= w_rm0;
      r_done  <= w_done;
      r_nop   <= w_nop;
    end
  end

  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_req   = r_req;
    w_addr  = r_addr;
    w_instr = r_instr;
    w_rm0   = r_rm0;
    w_done  = r_done;
    w_nop   = 1'b0;

    if (bus.branch_taken_in) begin
      w_pc    = w_target;
      w_nop   = 1'b1;
      w_done  = 1'b0;
      w_instr = NOP_INSTRUCTION;
      case (r_state)
        IDLE, VALID: begin
          w_req   = 1'b1;
          w_addr  = w_target;
          w_state = WAIT;
        end
        // A response already outstanding must be swallowed before re-requesting.
        WAIT, DRAIN: begin
          if (bus.icache_ready_in) begin
            w_req   = 1'b1;
            w_addr  = w_target;
            w_state = WAIT;
          end else begin
            w_req   = 1'b0;
            w_state = DRAIN;
          end
        end
        default: w_state = IDLE;
      endcase
    end else begin
      case (r_state)
        IDLE: begin
          w_req   = 1'b1;
          w_addr  = r_pc;
          w_state = WAIT;
        end
        WAIT: begin
          if (bus.icache_ready_in) begin
            w_instr = bus.icache_data_in;
            w_rm0   = r_addr;
            w_done  = 1'b1;
            w_req   = 1'b0;
            w_state = VALID;
          end
        end
        VALID: begin
          if (!bus.stall_in) begin
            w_pc    = w_pc_inc;
            w_req   = 1'b1;
            w_addr  = w_pc_inc;
            w_done  = 1'b0;
            w_instr = NOP_INSTRUCTION;
            w_state = WAIT;
          end
        end
        DRAIN: begin
          w_req = 1'b0;
          if (bus.icache_ready_in) begin
            w_req   = 1'b1;
            w_addr  = r_pc;
            w_state = WAIT;
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  assign bus.icache_req_out    = r_req;
  assign bus.icache_addr_out   = r_addr;
  assign bus.instruction_out   = r_instr;
  assign bus.rm0_out           = r_rm0;
  assign bus.cache_op_done_out = r_done;
  assign bus.set_nop_out       = r_nop;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  sb_t  sb[$];

  fetch_unit_if #(.WORD_WIDTH(32)) bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_valid(input string tag);
    sb_t e;
    int  n = 0;
    while (bus.cache_op_done_out !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_done"}, {31'd0, bus.cache_op_done_out}, 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_instr"}, bus.instruction_out, e.instr);
      check({tag, "_rm0"}, bus.rm0_out, e.pc);
    end
  endtask

  task automatic respond(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
    check({tag, "_req"}, {31'd0, bus.icache_req_out}, 32'd1);
    check({tag, "_addr"}, bus.icache_addr_out, exp_addr);
    sb.push_back('{pc: exp_addr, instr: data});
    bus.icache_ready_in = 1'b1;
    bus.icache_data_in  = data;
    tick();
    bus.icache_ready_in = 1'b0;
    bus.icache_data_in  = '0;
    pop_valid(tag);
  endtask

  task automatic branch(input logic [31:0] target, input logic ready, input logic [31:0] data);
    bus.branch_taken_in  = 1'b1;
    bus.branch_target_in = target;
    bus.icache_ready_in  = ready;
    bus.icache_data_in   = data;
    tick();
    bus.branch_taken_in  = 1'b0;
    bus.branch_target_in = '0;
    bus.icache_ready_in  = 1'b0;
    bus.icache_data_in   = '0;
  endtask

  initial begin
    reset                = 1'b0;
    bus.stall_in         = 1'b0;
    bus.branch_taken_in  = 1'b0;
    bus.branch_target_in = '0;
    bus.icache_ready_in  = 1'b0;
    bus.icache_data_in   = '0;
    tick();
    tick();

    check("rst_req", {31'd0, bus.icache_req_out}, 32'd0);
    check("rst_addr", bus.icache_addr_out, 32'd0);
    check("rst_instr", bus.instruction_out, NOP);
    check("rst_rm0", bus.rm0_out, 32'd0);
    check("rst_done", {31'd0, bus.cache_op_done_out}, 32'd0);
    check("rst_nop", {31'd0, bus.set_nop_out}, 32'd0);

    reset = 1'b1;
    tick();
    check("boot_req", {31'd0, bus.icache_req_out}, 32'd1);
    check("boot_addr", bus.icache_addr_out, 32'h0000_1000);
    tick();
    check("boot_addr_held", bus.icache_addr_out, 32'h0000_1000);
    respond("boot", 32'h0000_1000, 32'h00A0_0093);

    bus.stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_instr", bus.instruction_out, 32'h00A0_0093);
      check("stall_rm0", bus.rm0_out, 32'h0000_1000);
      check("stall_done", {31'd0, bus.cache_op_done_out}, 32'd1);
      check("stall_req", {31'd0, bus.icache_req_out}, 32'd0);
    end
    bus.stall_in = 1'b0;
    tick();
    check("seq_done", {31'd0, bus.cache_op_done_out}, 32'd0);
    check("seq_instr", bus.instruction_out, NOP);
    respond("seq", 32'h0000_1004, 32'h0010_0113);

    branch(32'h0000_2003, 1'b0, '0);
    check("brv_nop", {31'd0, bus.set_nop_out}, 32'd1);
    check("brv_done", {31'd0, bus.cache_op_done_out}, 32'd0);
    check("brv_instr", bus.instruction_out, NOP);
    tick();
    check("brv_nop_pulse", {31'd0, bus.set_nop_out}, 32'd0);
    respond("brv", 32'h0000_2000, 32'h0020_0193);

    tick();
    check("brw_pre_addr", bus.icache_addr_out, 32'h0000_2004);
    branch(32'h0000_3000, 1'b0, '0);
    check("brw_req_drop", {31'd0, bus.icache_req_out}, 32'd0);
    check("brw_nop", {31'd0, bus.set_nop_out}, 32'd1);
    tick();
    check("brw_drain_req", {31'd0, bus.icache_req_out}, 32'd0);
    bus.icache_ready_in = 1'b1;
    bus.icache_data_in  = 32'hDEAD_BEEF;
    tick();
    bus.icache_ready_in = 1'b0;
    bus.icache_data_in  = '0;
    check("brw_stale_instr", bus.instruction_out, NOP);
    check("brw_stale_done", {31'd0, bus.cache_op_done_out}, 32'd0);
    respond("brw", 32'h0000_3000, 32'h0030_0213);

    tick();
    check("brr_pre_addr", bus.icache_addr_out, 32'h0000_3004);
    branch(32'h0000_4000, 1'b1, 32'hBAD0_BAD0);
    check("brr_req", {31'd0, bus.icache_req_out}, 32'd1);
    check("brr_nop", {31'd0, bus.set_nop_out}, 32'd1);
    check("brr_instr", bus.instruction_out, NOP);
    tick();
    check("brr_no_drain", {31'd0, bus.icache_req_out}, 32'd1);
    respond("brr", 32'h0000_4000, 32'h0040_0293);

    branch(32'hFFFF_FFFC, 1'b0, '0);
    respond("wrap_top", 32'hFFFF_FFFC, 32'h0050_0313);
    tick();
    respond("wrap", 32'h0000_0000, 32'h0060_0393);

    tick();
    check("rmid_addr", bus.icache_addr_out, 32'h0000_0004);
    #2;
    reset = 1'b0;
    #1;
    check("rmid_req", {31'd0, bus.icache_req_out}, 32'd0);
    check("rmid_done", {31'd0, bus.cache_op_done_out}, 32'd0);
    tick();
    bus.icache_ready_in = 1'b1;
    bus.icache_data_in  = 32'hDEAD_BEEF;
    reset = 1'b1;
    tick();
    bus.icache_ready_in = 1'b0;
    bus.icache_data_in  = '0;
    check("rmid_idle_ignored", bus.instruction_out, NOP);
    check("rmid_done2", {31'd0, bus.cache_op_done_out}, 32'd0);
    respond("rmid", 32'h0000_1000, 32'h0070_0413);

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
